// File: rtl/prbs31_ber_check.sv
// rtl/prbs31_ber_check.sv - PRBS31 (x^31+x^28+1) bit-error-rate checker behind the 64-bit word aligner
module prbs31_ber_check #(
    parameter logic [63:0] SYNC_WORD  = 64'hF731_8CEF_137F_FEC8,
    parameter int          CNT_W      = 48,
    parameter int          LOSS_ERR   = 8,
    parameter int          LOSS_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             phy_init,
    input  logic             clr,
    input  logic             aligned,
    input  logic             dipush,
    input  logic [63:0]      din,
    output logic             locked,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] err_words,
    output logic             loss_evt
);

    typedef enum logic [1:0] {IDLE, HUNT, SEED, CHECK} state_t;

    state_t      state, state_nxt;
    logic [63:0] ref_word;
    logic [63:0] x1;
    logic        v1;
    logic [6:0]  pc1, pc2;
    logic        v2;
    logic [7:0]  bad_run;
    logic        bad2, loss;

    // t[] holds the stream in wire order (t[0] earliest); the new word extends it by 64 bits.
    function automatic logic [63:0] prbs_advance(input logic [63:0] cur);
        logic [127:0] t;
        logic [63:0]  res;
        t   = '0;
        res = '0;
        for (int i = 0; i < 64; i++) t[i] = cur[63-i];
        for (int j = 64; j < 128; j++) t[j] = t[j-31] ^ t[j-28];
        for (int j = 0; j < 64; j++) res[63-j] = t[64+j];
        return res;
    endfunction

    function automatic logic [6:0] popcount(input logic [63:0] x);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) n = n + 7'(x[i]);
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_comb begin
        pc1       = popcount(x1);
        bad2      = v2 && (int'(pc2) > LOSS_ERR);
        state_nxt = state;
        loss      = 1'b0;
        case (state)
            IDLE:  if (aligned) state_nxt = HUNT;
            HUNT:  if (dipush && din == SYNC_WORD) state_nxt = SEED;
            SEED:  if (dipush) state_nxt = CHECK;
            CHECK: if (bad2 && int'(bad_run) == LOSS_WORDS - 1) begin
                       state_nxt = SEED;
                       loss      = 1'b1;
                   end
            default: state_nxt = IDLE;
        endcase
        // PHY_INIT outranks a dropped ALIGNED; neither counts as a lock-loss event.
        if (!aligned) begin
            state_nxt = IDLE;
            loss      = 1'b0;
        end
        if (phy_init) begin
            state_nxt = HUNT;
            loss      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ref_word  <= '0;
            x1        <= '0;
            v1        <= 1'b0;
            pc2       <= '0;
            v2        <= 1'b0;
            bad_run   <= '0;
            locked    <= 1'b0;
            loss_evt  <= 1'b0;
            bit_cnt   <= '0;
            err_cnt   <= '0;
            err_words <= '0;
        end else begin
            state    <= state_nxt;
            locked   <= (state_nxt == CHECK);
            loss_evt <= loss;

            x1 <= din ^ ref_word;
            v1 <= dipush && (state == CHECK);
            // Reference free-runs from its own state once seeded; received data never feeds it.
            if (dipush && (state == SEED || state == CHECK))
                ref_word <= prbs_advance((state == SEED) ? din : ref_word);

            pc2 <= pc1;
            v2  <= v1;

            if (state != CHECK || loss)
                bad_run <= '0;
            else if (v2)
                bad_run <= bad2 ? bad_run + 8'd1 : 8'd0;

            if (clr) begin
                bit_cnt   <= '0;
                err_cnt   <= '0;
                err_words <= '0;
            end else if (v1) begin
                bit_cnt <= sat_add(bit_cnt, CNT_W'(64));
                err_cnt <= sat_add(err_cnt, CNT_W'(pc1));
                if (pc1 != 7'd0) err_words <= sat_add(err_words, CNT_W'(1));
            end
        end
    end

endmodule
